// File: rtl/mux_select_config_cell.sv
// Configuration cell for a routing mux: serially loaded multi-context select
// schedule, validated and copied to shadow registers on commit, then stepped one context per cycle.
module mux_select_config_cell #(
  parameter int unsigned SEL_WIDTH  = 4,
  parameter int unsigned NUM_INPUTS = 10,
  parameter int unsigned CONTEXTS   = 4,
  localparam int unsigned CHAIN_LEN = CONTEXTS * SEL_WIDTH,
  localparam int unsigned CTX_W     = (CONTEXTS > 1) ? $clog2(CONTEXTS) : 1
) (
  input  logic                 CGRA_Clock,
  input  logic                 CGRA_Reset,
  input  logic                 ConfigIn,
  output logic                 ConfigOut,
  input  logic                 config_shift_en,
  input  logic                 config_commit,
  input  logic                 ctx_run,
  output logic [SEL_WIDTH-1:0] select,
  output logic                 select_valid,
  output logic [CTX_W-1:0]     ctx_index,
  output logic                 cfg_error
);

  logic [CHAIN_LEN-1:0] chain;
  logic [SEL_WIDTH-1:0] shadow [CONTEXTS];
  logic [CTX_W-1:0]     ctx;
  logic                 valid_q;
  logic                 err_q;

  logic                 all_legal;
  logic                 commit_ok;
  logic [CTX_W-1:0]     ctx_nxt;

  // Every field of the pre-shift chain must address a real mux input
  always_comb begin
    all_legal = 1'b1;
    for (int k = 0; k < int'(CONTEXTS); k++) begin
      if (32'(chain[k*SEL_WIDTH +: SEL_WIDTH]) >= NUM_INPUTS) begin
        all_legal = 1'b0;
      end
    end
  end

  assign commit_ok = config_commit && all_legal;
  assign ctx_nxt   = (ctx == CTX_W'(CONTEXTS - 1)) ? '0 : ctx + CTX_W'(1);

  always_ff @(posedge CGRA_Clock) begin
    if (CGRA_Reset) begin
      chain   <= '0;
      ctx     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      for (int k = 0; k < int'(CONTEXTS); k++) begin
        shadow[k] <= '0;
      end
    end else begin
      if (config_shift_en) begin
        chain <= {ConfigIn, chain[CHAIN_LEN-1:1]};
      end
      // An accepted commit restarts the schedule and overrides ctx_run
      if (commit_ok) begin
        for (int k = 0; k < int'(CONTEXTS); k++) begin
          shadow[k] <= chain[k*SEL_WIDTH +: SEL_WIDTH];
        end
        valid_q <= 1'b1;
        ctx     <= '0;
      end else if (ctx_run) begin
        ctx <= ctx_nxt;
      end
      if (config_commit && !all_legal) begin
        err_q <= 1'b1;
      end
    end
  end

  // Register-only decode of the current context's select field
  always_comb begin
    select = '0;
    for (int k = 0; k < int'(CONTEXTS); k++) begin
      if (ctx == CTX_W'(k)) begin
        select = shadow[k];
      end
    end
  end

  assign ConfigOut    = chain[0];
  assign select_valid = valid_q;
  assign ctx_index    = ctx;
  assign cfg_error    = err_q;

endmodule

// File: tb/tb_mux_select_config_cell.sv
// Directed bench for mux_select_config_cell: default 4-context cell plus a 1-context cell.
module tb_mux_select_config_cell;

  logic       clk;
  logic       rst;
  logic       cin, sh, cm, rn;
  logic       cout;
  logic [3:0] sel;
  logic       vld;
  logic [1:0] ctx;
  logic       err;

  logic       cin1, sh1, cm1, rn1;
  logic       cout1;
  logic [3:0] sel1;
  logic       vld1;
  logic [0:0] ctx1;
  logic       err1;

  int total = 0;
  int bad   = 0;

  mux_select_config_cell dut (
    .CGRA_Clock(clk), .CGRA_Reset(rst), .ConfigIn(cin), .ConfigOut(cout),
    .config_shift_en(sh), .config_commit(cm), .ctx_run(rn),
    .select(sel), .select_valid(vld), .ctx_index(ctx), .cfg_error(err)
  );

  mux_select_config_cell #(.CONTEXTS(1)) dut1 (
    .CGRA_Clock(clk), .CGRA_Reset(rst), .ConfigIn(cin1), .ConfigOut(cout1),
    .config_shift_en(sh1), .config_commit(cm1), .ctx_run(rn1),
    .select(sel1), .select_valid(vld1), .ctx_index(ctx1), .cfg_error(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shift 16 bits LSB-first; cap collects ConfigOut seen before each shift
  task automatic shift_word(input logic [15:0] data, output logic [15:0] cap);
    for (int i = 0; i < 16; i++) begin
      cap[i] = cout;
      cin    = data[i];
      sh     = 1'b1;
      step();
    end
    sh  = 1'b0;
    cin = 1'b0;
  endtask

  task automatic commit();
    cm = 1'b1;
    step();
    cm = 1'b0;
  endtask

  logic [15:0] cap;
  int exp_sel [5] = '{9, 0, 7, 3, 9};
  int exp_ctx [5] = '{1, 2, 3, 0, 1};
  int rej_sel [4] = '{0, 7, 3, 9};
  int rej_ctx [4] = '{2, 3, 0, 1};
  logic [3:0] five = 4'h5;

  initial begin
    rst = 1'b1; cin = 0; sh = 0; cm = 0; rn = 0;
    cin1 = 0; sh1 = 0; cm1 = 0; rn1 = 0;
    step();
    rst = 1'b0;
    chk("rst_select", sel, 0);
    chk("rst_valid", vld, 0);
    chk("rst_err", err, 0);
    chk("rst_ctx", ctx, 0);
    chk("rst_cout", cout, 0);

    // Legal load and run
    shift_word(16'h7093, cap);
    commit();
    chk("load_valid", vld, 1);
    chk("load_select", sel, 3);
    chk("load_ctx", ctx, 0);
    rn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("run_select", sel, exp_sel[i]);
      chk("run_ctx", ctx, exp_ctx[i]);
    end
    rn = 1'b0;
    step();
    chk("hold_select", sel, 9);
    chk("hold_ctx", ctx, 1);

    // Illegal commit leaves the schedule intact
    shift_word(16'h70A3, cap);
    commit();
    chk("illegal_err", err, 1);
    chk("illegal_valid", vld, 1);
    chk("illegal_select", sel, 9);
    rn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("illegal_run_select", sel, rej_sel[i]);
      chk("illegal_run_ctx", ctx, rej_ctx[i]);
    end
    rn = 1'b0;

    // All-9 schedule, committed with ctx_run high at ctx=2
    shift_word(16'h9999, cap);
    rn = 1'b1;
    step();
    chk("pre_commit_ctx", ctx, 2);
    commit();
    rn = 1'b0;
    chk("commit_run_ctx", ctx, 0);
    chk("commit_run_select", sel, 9);
    chk("commit_9999_valid", vld, 1);

    // Commit and shift in the same cycle
    shift_word(16'h7093, cap);
    cm = 1'b1; sh = 1'b1; cin = 1'b1;
    step();
    cm = 1'b0; sh = 1'b0; cin = 1'b0;
    chk("cs_select", sel, 3);
    chk("cs_ctx", ctx, 0);
    chk("cs_cout", cout, 1);
    shift_word(16'h1234, cap);
    chk("cs_chain", cap, 16'hB849);

    // Daisy chain: 32 bits through a cell holding 0x1234
    shift_word(16'hABCD, cap);
    chk("daisy_first", cap, 16'h1234);
    shift_word(16'h5678, cap);
    chk("daisy_second", cap, 16'hABCD);
    commit();
    chk("daisy_hold_select", sel, 8);

    // Reset during a run
    rn = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rn  = 1'b0;
    chk("midrun_select", sel, 0);
    chk("midrun_valid", vld, 0);
    chk("midrun_err", err, 0);
    chk("midrun_ctx", ctx, 0);
    chk("midrun_cout", cout, 0);

    // All-15 schedule rejected; run still advances with no valid schedule
    shift_word(16'hFFFF, cap);
    commit();
    chk("ffff_err", err, 1);
    chk("ffff_valid", vld, 0);
    chk("ffff_select", sel, 0);
    rn = 1'b1;
    step();
    step();
    rn = 1'b0;
    chk("invalid_run_ctx", ctx, 2);
    chk("invalid_run_select", sel, 0);

    // Single-context cell holds select constant while running
    for (int i = 0; i < 4; i++) begin
      cin1 = five[i];
      sh1  = 1'b1;
      step();
    end
    sh1 = 1'b0; cin1 = 1'b0;
    cm1 = 1'b1;
    step();
    cm1 = 1'b0;
    chk("c1_valid", vld1, 1);
    chk("c1_select", sel1, 5);
    rn1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("c1_run_select", sel1, 5);
      chk("c1_run_ctx", ctx1, 0);
    end
    rn1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
